seq_squarer: RTL

- Sequential squarer: computes root² by accumulating successive odd numbers (0+1+3+5+…).
- It is the inverse of the iterative square-root unit and uses the same square/odd-increment datapath run in the opposite direction.
- Sits beside the square-root core.
- Used as a golden-result generator and round-trip checker: sqrt(x) → seq_squarer → compare against x.

---
 rtl/sqrt_pkg.sv | 22 ++
 rtl/reg_en_init.sv | 27 ++
 rtl/seq_squarer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root core and its companion squarer:
// FSM state encoding, operand widths and datapath reset values.
package sqrt_pkg;

    // Root operand width and square result width (SQ_W >= 2*ROOT_W+1 keeps
    // the largest square, (2^ROOT_W-1)^2, inside the result with no wrap).
    localparam int ROOT_W = 8;
    localparam int SQ_W   = 17;

    // Control states shared by the iterative units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Datapath reset values: the running square starts at 0 and the odd
    // increment starts at 1 (the first term of 1+3+5+...).
    localparam logic [SQ_W-1:0] SQUARE_RST = '0;
    localparam logic [SQ_W-1:0] ODD_RST    = SQ_W'(1);

endpackage : sqrt_pkg

// File: rtl/reg_en_init.sv
// Generic register with a load enable and a configurable value loaded by the
// asynchronous active-low reset.
module reg_en_init #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clock,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Capture i_d on enabled edges; reset forces the configured initial value.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RESET_VALUE;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : reg_en_init

// File: rtl/seq_squarer.sv
// Sequential squarer: builds root^2 by summing the first root odd numbers,
// one term per enabled clock. Used to regenerate x from sqrt(x) for
// round-trip checking of the square-root core.
module seq_squarer
    import sqrt_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic [ROOT_W-1:0] root,
    output logic [SQ_W-1:0]   square,
    output logic              busy,
    output logic              done
);

    state_t r_state;
    logic   r_busy;
    logic   r_done;

    logic [SQ_W-1:0]   w_square_q;
    logic [SQ_W-1:0]   w_square_d;
    logic [SQ_W-1:0]   w_odd_q;
    logic [SQ_W-1:0]   w_odd_d;
    logic [ROOT_W-1:0] w_count_q;
    logic [ROOT_W-1:0] w_count_d;
    logic              w_accept;
    logic              w_step;
    logic              w_load;

    // A start is only honoured in IDLE on an enabled edge; every ITER edge
    // adds one odd term. Nothing else touches the datapath, so DONE and IDLE
    // hold the last square.
    assign w_accept = enable && (r_state == IDLE) && start;
    assign w_step   = enable && (r_state == ITER);
    assign w_load   = w_accept || w_step;

    // Datapath next values: initialise on accept, otherwise advance one term.
    always_comb begin
        w_square_d = w_square_q + w_odd_q;
        w_odd_d    = w_odd_q + SQ_W'(2);
        w_count_d  = w_count_q - ROOT_W'(1);
        if (w_accept) begin
            w_square_d = SQUARE_RST;
            w_odd_d    = ODD_RST;
            w_count_d  = root;
        end
    end

    reg_en_init #(
        .WIDTH       (SQ_W),
        .RESET_VALUE (SQUARE_RST)
    ) u_square_reg (
        .i_clock (clock),
        .i_rst_n (reset),
        .i_load  (w_load),
        .i_d     (w_square_d),
        .o_q     (w_square_q)
    );

    reg_en_init #(
        .WIDTH       (SQ_W),
        .RESET_VALUE (ODD_RST)
    ) u_odd_reg (
        .i_clock (clock),
        .i_rst_n (reset),
        .i_load  (w_load),
        .i_d     (w_odd_d),
        .o_q     (w_odd_q)
    );

    reg_en_init #(
        .WIDTH       (ROOT_W),
        .RESET_VALUE ('0)
    ) u_count_reg (
        .i_clock (clock),
        .i_rst_n (reset),
        .i_load  (w_load),
        .i_d     (w_count_d),
        .o_q     (w_count_q)
    );

    // Control FSM; busy/done are registered alongside the state so they are
    // exact Moore decodes (busy: ITER or DONE, done: DONE only).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (enable) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // A zero root needs no iterations at all.
                        if (root == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ITER;
                            r_done  <= 1'b0;
                        end
                        r_busy <= 1'b1;
                    end
                end
                ITER: begin
                    // count==1 means this edge adds the last odd term.
                    if (w_count_q == ROOT_W'(1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign square = w_square_q;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule : seq_squarer
